// File: rtl/hall_input_conditioner.sv
// Hall sensor input conditioner: synchronises the three raw Hall pins, debounces them with a
// stability filter, rejects the illegal codes 000/111, flags a stalled rotor and strobes once
// per accepted commutation. Everything runs on pclk; no output is combinational from hall_raw.
module hall_input_conditioner #(
    parameter int unsigned clk_freq_hz   = 54_000_000,
    parameter int unsigned sync_stages   = 2,
    parameter int unsigned filter_cycles = 32,
    parameter int unsigned stall_ms      = 100
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic [2:0]  hall_raw,
    input  logic        clear_stats,
    output logic [2:0]  hall_values,
    output logic        hall_valid,
    output logic        hall_edge,
    output logic        hall_invalid,
    output logic        invalid_sticky,
    output logic        stalled,
    output logic [15:0] glitch_count
);

    localparam int unsigned stall_cycles = clk_freq_hz / 1000 * stall_ms;
    localparam int unsigned stall_w      = $clog2(stall_cycles + 1);
    localparam int unsigned fcnt_w       = (filter_cycles > 1) ? $clog2(filter_cycles) : 1;

    localparam logic [fcnt_w-1:0]  fcnt_max  = fcnt_w'(filter_cycles - 1);
    localparam logic [stall_w-1:0] stall_max = stall_w'(stall_cycles);
    localparam logic [stall_w-1:0] stall_pre = stall_w'(stall_cycles - 1);
    localparam logic [15:0]        glitch_max = 16'hFFFF;

    // Elaboration-time parameter sanity
    if (sync_stages < 2) begin : g_bad_sync
        $error("hall_input_conditioner: sync_stages must be >= 2");
    end
    if (filter_cycles < 1) begin : g_bad_filter
        $error("hall_input_conditioner: filter_cycles must be >= 1");
    end
    if (stall_cycles < 1) begin : g_bad_stall
        $error("hall_input_conditioner: stall_cycles must be >= 1");
    end

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [2:0] sync_q [sync_stages];
    logic [2:0] synced;

    // Shift raw pins through the synchroniser chain
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < int'(sync_stages); i++) begin
                sync_q[i] <= 3'b000;
            end
        end else begin
            sync_q[0] <= hall_raw;
            for (int i = 1; i < int'(sync_stages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[sync_stages-1];

    // ------------------------------------------------------------------
    // Filter, accept, statistics and stall state
    // ------------------------------------------------------------------
    logic [2:0]         cand_q, cand_d;
    logic [fcnt_w-1:0]  fcnt_q, fcnt_d;
    // Last accepted code, valid or not; prevents re-accepting the same code
    logic [2:0]         acc_code_q, acc_code_d;
    logic [2:0]         values_q, values_d;
    logic               valid_q, valid_d;
    logic               edge_q, edge_d;
    logic               invalid_q, invalid_d;
    logic               sticky_q, sticky_d;
    logic [15:0]        glitch_q, glitch_d;
    logic [stall_w-1:0] stall_cnt_q, stall_cnt_d;
    logic               stalled_q, stalled_d;

    logic accept;
    logic code_ok;
    logic glitch;

    // Next-state: debounce filter, accept decision, counters
    always_comb begin
        cand_d      = cand_q;
        fcnt_d      = fcnt_q;
        acc_code_d  = acc_code_q;
        values_d    = values_q;
        valid_d     = valid_q;
        edge_d      = 1'b0;
        invalid_d   = invalid_q;
        sticky_d    = sticky_q;
        glitch_d    = glitch_q;
        stall_cnt_d = stall_cnt_q;
        stalled_d   = stalled_q;
        accept      = 1'b0;
        glitch      = 1'b0;
        code_ok     = (cand_q != 3'b000) && (cand_q != 3'b111);

        if (synced != cand_q) begin
            cand_d = synced;
            fcnt_d = '0;
            // An abandoned candidate that never made it to acceptance is a glitch
            glitch = (cand_q != acc_code_q);
        end else if (fcnt_q != fcnt_max) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (cand_q != acc_code_q) begin
            accept = 1'b1;
        end

        if (accept) begin
            acc_code_d = cand_q;
            if (code_ok) begin
                values_d  = cand_q;
                valid_d   = 1'b1;
                invalid_d = 1'b0;
                edge_d    = 1'b1;
            end else begin
                invalid_d = 1'b1;
                sticky_d  = 1'b1;
            end
        end

        // A valid accept restarts stall timing and beats a coincident threshold hit
        if (accept && code_ok) begin
            stall_cnt_d = '0;
            stalled_d   = 1'b0;
        end else if (valid_q && !stalled_q) begin
            if (stall_cnt_q == stall_pre) begin
                stall_cnt_d = stall_max;
                stalled_d   = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end

        if (glitch && (glitch_q != glitch_max)) begin
            glitch_d = glitch_q + 16'd1;
        end

        // Clear has priority over a coincident glitch or invalid accept
        if (clear_stats) begin
            glitch_d = '0;
            sticky_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cand_q      <= 3'b000;
            fcnt_q      <= '0;
            acc_code_q  <= 3'b000;
            values_q    <= 3'b000;
            valid_q     <= 1'b0;
            edge_q      <= 1'b0;
            invalid_q   <= 1'b0;
            sticky_q    <= 1'b0;
            glitch_q    <= '0;
            stall_cnt_q <= '0;
            stalled_q   <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            fcnt_q      <= fcnt_d;
            acc_code_q  <= acc_code_d;
            values_q    <= values_d;
            valid_q     <= valid_d;
            edge_q      <= edge_d;
            invalid_q   <= invalid_d;
            sticky_q    <= sticky_d;
            glitch_q    <= glitch_d;
            stall_cnt_q <= stall_cnt_d;
            stalled_q   <= stalled_d;
        end
    end

    assign hall_values    = values_q;
    assign hall_valid     = valid_q;
    assign hall_edge      = edge_q;
    assign hall_invalid   = invalid_q;
    assign invalid_sticky = sticky_q;
    assign stalled        = stalled_q;
    assign glitch_count   = glitch_q;

endmodule

// File: tb/tb_hall_input_conditioner.sv
// Scoreboard bench for hall_input_conditioner: stimulus pushes expected states and edges keyed
// by cycle number; a negedge monitor pops and compares them against the DUT outputs.
module tb_hall_input_conditioner;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic [2:0]  hall_raw = 3'b000;
    logic        clear_stats = 1'b0;
    logic [2:0]  hall_values;
    logic        hall_valid;
    logic        hall_edge;
    logic        hall_invalid;
    logic        invalid_sticky;
    logic        stalled;
    logic [15:0] glitch_count;

    hall_input_conditioner #(
        .clk_freq_hz  (10_000),
        .sync_stages  (2),
        .filter_cycles(4),
        .stall_ms     (100)
    ) dut (
        .pclk          (pclk),
        .preset_n      (preset_n),
        .hall_raw      (hall_raw),
        .clear_stats   (clear_stats),
        .hall_values   (hall_values),
        .hall_valid    (hall_valid),
        .hall_edge     (hall_edge),
        .hall_invalid  (hall_invalid),
        .invalid_sticky(invalid_sticky),
        .stalled       (stalled),
        .glitch_count  (glitch_count)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  vals;
        logic        valid;
        logic        invalid;
        logic        sticky;
        logic        stalled;
        logic [15:0] gc;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [2:0] vals;
    } edge_t;

    exp_t  chk_q[$];
    edge_t edge_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    logic  done = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic expect_state(input int dly, input string name, input logic [2:0] v,
                                input logic va, input logic inv, input logic st,
                                input logic sl, input logic [15:0] gc);
        exp_t e;
        e.cyc = cyc + dly;
        e.name = name;
        e.vals = v;
        e.valid = va;
        e.invalid = inv;
        e.sticky = st;
        e.stalled = sl;
        e.gc = gc;
        chk_q.push_back(e);
    endtask

    task automatic expect_edge(input int dly, input logic [2:0] v);
        edge_t e;
        e.cyc = cyc + dly;
        e.vals = v;
        edge_q.push_back(e);
    endtask

    // Monitor: edge strobes and scheduled state snapshots, then end-of-run bookkeeping
    always @(negedge pclk) begin
        exp_t  e;
        edge_t ed;
        if (hall_edge === 1'b1) begin
            checks++;
            if (edge_q.size() == 0 || edge_q[0].cyc != cyc) begin
                errors++;
                $display("FAIL edge_unexpected: hall_edge=1 at cycle %0d (hall_values=%b), none expected",
                         cyc, hall_values);
            end else begin
                ed = edge_q.pop_front();
                if (hall_values !== ed.vals) begin
                    errors++;
                    $display("FAIL edge_value: cycle %0d hall_values=%b, expected %b",
                             cyc, hall_values, ed.vals);
                end
            end
        end else if (edge_q.size() != 0 && edge_q[0].cyc <= cyc) begin
            ed = edge_q.pop_front();
            checks++;
            errors++;
            $display("FAIL edge_missing: hall_edge=%b at cycle %0d, expected 1 (value %b)",
                     hall_edge, ed.cyc, ed.vals);
        end

        while (chk_q.size() != 0 && chk_q[0].cyc <= cyc) begin
            e = chk_q.pop_front();
            checks++;
            if (e.cyc != cyc ||
                hall_values !== e.vals || hall_valid !== e.valid ||
                hall_invalid !== e.invalid || invalid_sticky !== e.sticky ||
                stalled !== e.stalled || glitch_count !== e.gc) begin
                errors++;
                $display("FAIL %s @%0d: got vals=%b valid=%b inv=%b sticky=%b stalled=%b gc=%0d; expected vals=%b valid=%b inv=%b sticky=%b stalled=%b gc=%0d (for cycle %0d)",
                         e.name, cyc, hall_values, hall_valid, hall_invalid, invalid_sticky,
                         stalled, glitch_count, e.vals, e.valid, e.invalid, e.sticky,
                         e.stalled, e.gc, e.cyc);
            end
        end

        if (done) begin
            checks++;
            if (edge_q.size() != 0) begin
                errors++;
                $display("FAIL edge_queue_drain: %0d expected edges left, expected 0",
                         edge_q.size());
            end
            checks++;
            if (chk_q.size() != 0) begin
                errors++;
                $display("FAIL state_queue_drain: %0d expected states left, expected 0",
                         chk_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Stimulus: directed vectors; latency is 2 sync + 4 filter + 1 accept = 7 cycles
    initial begin
        step(3);
        expect_state(0, "reset", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        preset_n = 1'b1;
        step(2);

        // T1: 000 -> 101 held
        hall_raw = 3'b101;
        expect_edge(7, 3'b101);
        expect_state(6, "t1_before", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(7, "t1_accept", 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        step(12);

        // T2: 3-cycle pulse to 100 is rejected as a glitch
        hall_raw = 3'b100;
        expect_state(10, "t2_glitch", 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        step(3);
        hall_raw = 3'b101;
        step(12);

        // T3: invalid 111 held 10 cycles, then 100, then clear
        hall_raw = 3'b111;
        expect_state(6, "t3_before_inv", 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        expect_state(7, "t3_invalid", 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
        step(10);
        hall_raw = 3'b100;
        expect_edge(7, 3'b100);
        expect_state(6, "t3_inv_held", 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
        expect_state(7, "t3_valid", 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        step(10);
        clear_stats = 1'b1;
        expect_state(1, "t3_clear", 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        step(1);
        clear_stats = 1'b0;
        step(3);

        // T6: clear coincides with a glitch increment
        hall_raw = 3'b011;
        step(2);
        hall_raw = 3'b100;
        step(2);
        clear_stats = 1'b1;
        expect_state(1, "t6_clear_wins", 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        step(1);
        clear_stats = 1'b0;
        expect_state(3, "t6_after", 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        step(6);

        // T4: stall after 1000 cycles, then unstall on the next accept
        hall_raw = 3'b110;
        expect_edge(7, 3'b110);
        expect_state(7, "t4_accept", 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(1006, "t4_pre_stall", 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(1007, "t4_stalled", 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        step(1012);
        hall_raw = 3'b010;
        expect_edge(7, 3'b010);
        expect_state(6, "t4_still_stalled", 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        expect_state(7, "t4_unstall", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        step(1000);
        // Next accept lands exactly on the stall threshold cycle
        hall_raw = 3'b011;
        expect_edge(7, 3'b011);
        expect_state(6, "t4_near_thr", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(7, "t4_accept_wins", 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(8, "t4_no_stall_after", 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        step(12);

        // T5: reset during filter count, then during stall counting
        hall_raw = 3'b101;
        step(3);
        preset_n = 1'b0;
        expect_state(0, "t5_reset_mid_filter", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        step(1);
        preset_n = 1'b1;
        expect_edge(7, 3'b101);
        expect_state(6, "t5_pre", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(7, "t5_full_latency", 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        step(500);
        preset_n = 1'b0;
        expect_state(0, "t5_reset_mid_stall", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        step(1);
        preset_n = 1'b1;
        expect_edge(7, 3'b101);
        expect_state(6, "t5_pre2", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(7, "t5_reaccept", 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(1006, "t5_stall_restart_pre", 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_state(1007, "t5_stall_restart", 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        step(1015);

        done = 1'b1;
    end

endmodule
